// File: rtl/qsys_system_mul_sequencer_pkg.sv
// Shared types and constants for the 32x32 multiply sequencer and its 16x16 cell.
package qsys_system_mul_sequencer_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_HALF_W = MUL_DATA_W / 2;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXSS = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXUU = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIX,
        ST_RESP
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [MUL_DATA_W-1:0] a;
        logic [MUL_DATA_W-1:0] b;
    } mul_req_t;

endpackage

// File: rtl/qsys_system_mul16_cell.sv
// Registered unsigned HALF_W x HALF_W multiplier; output holds while ena is low.
module qsys_system_mul16_cell
    import qsys_system_mul_sequencer_pkg::*;
#(
    parameter int HALF_W = MUL_HALF_W
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                ena,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            p <= '0;
        else if (ena)
            p <= a * b;
    end

endmodule

// File: rtl/qsys_system_mul_sequencer.sv
// Multi-cycle 32x32 multiply controller: issues partial products to one 16x16 cell,
// accumulates them in 64 bits, then applies the signed high-word correction.
module qsys_system_mul_sequencer
    import qsys_system_mul_sequencer_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W  // only 32 is supported
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy
);

    localparam int HALF_W = DATA_W / 2;

    state_e              state;
    mul_req_t            req_q;
    logic [1:0]          k;
    logic [1:0]          cell_idx;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] pp_sh;
    logic [DATA_W-1:0]   corr;
    logic [DATA_W-1:0]   hi_fix;
    logic [DATA_W-1:0]   cell_p;
    logic [HALF_W-1:0]   cell_a;
    logic [HALF_W-1:0]   cell_b;
    logic                last_issue;

    assign req_ready = (state == ST_IDLE) && !flush;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // k[1] picks the A half, k[0] picks the B half: k0=lo*lo, k1=lo*hi, k2=hi*lo, k3=hi*hi
    assign cell_a     = k[1] ? req_q.a[DATA_W-1:HALF_W] : req_q.a[HALF_W-1:0];
    assign cell_b     = k[0] ? req_q.b[DATA_W-1:HALF_W] : req_q.b[HALF_W-1:0];
    assign last_issue = (req_q.op == OP_MUL) ? (k == 2'd2) : (k == 2'd3);

    qsys_system_mul16_cell #(.HALF_W(HALF_W)) u_cell (
        .clk  (clk),
        .aclr (~reset_n),
        .ena  (state == ST_ISSUE),
        .a    (cell_a),
        .b    (cell_b),
        .p    (cell_p)
    );

    // cell_idx tracks which partial product the cell register currently holds
    always_comb begin
        pp_sh = '0;
        case (cell_idx)
            2'd0:       pp_sh = {{DATA_W{1'b0}}, cell_p};
            2'd1, 2'd2: pp_sh = {{HALF_W{1'b0}}, cell_p, {HALF_W{1'b0}}};
            default:    pp_sh = {cell_p, {DATA_W{1'b0}}};
        endcase
    end

    always_comb begin
        corr = '0;
        case (req_q.op)
            OP_MULXSS: corr = (req_q.a[DATA_W-1] ? req_q.b : '0)
                            + (req_q.b[DATA_W-1] ? req_q.a : '0);
            OP_MULXSU: corr = req_q.a[DATA_W-1] ? req_q.b : '0;
            default:   corr = '0;
        endcase
    end

    assign hi_fix = acc[2*DATA_W-1:DATA_W] - corr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            k          <= '0;
            cell_idx   <= '0;
            acc        <= '0;
            rsp_result <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    req_q <= '{op: op_e'(req_op), a: req_src1, b: req_src2};
                    acc   <= '0;
                    k     <= '0;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (k != 2'd0)
                        acc <= acc + pp_sh;
                    cell_idx <= k;
                    if (last_issue)
                        state <= ST_DRAIN;
                    else
                        k <= k + 2'd1;
                end
                ST_DRAIN: begin
                    acc   <= acc + pp_sh;
                    state <= ST_FIX;
                end
                ST_FIX: begin
                    rsp_result <= (req_q.op == OP_MUL) ? acc[DATA_W-1:0] : hi_fix;
                    state      <= ST_RESP;
                end
                ST_RESP: if (rsp_ready)
                    state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
